// File: rtl/barcode_tx_if.sv
// ---------------------------------------------------------------------------
// barcode_tx_if
// Bundles the barcode transmitter's request and line signals.
//   period     : bit-cell length in clocks (master -> slave)
//   send       : one-cycle start strobe (master -> slave)
//   station_ID : ID to transmit (master -> slave)
//   BC         : barcode line, idles high (slave -> master)
//   BC_done    : one-cycle frame-complete pulse (slave -> master)
// ---------------------------------------------------------------------------
interface barcode_tx_if;
    logic [21:0] period;
    logic        send;
    logic [7:0]  station_ID;
    logic        BC;
    logic        BC_done;

    modport slave  (input  period, send, station_ID, output BC, BC_done);
    modport master (output period, send, station_ID, input  BC, BC_done);
endinterface

// File: rtl/barcode_tx.sv
// ---------------------------------------------------------------------------
// barcode_tx
// Serializes an 8-bit station ID onto a pulse-width-encoded barcode line.
// Each frame is a start cell followed by 8 data cells (MSB first); every
// cell is P clocks long and starts with a falling edge of BC. Low time is
// P>>1 for the start cell, P>>2 for a '1' and P-(P>>2) for a '0'.
//
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   bus    : barcode_tx_if.slave (period, send, station_ID, BC, BC_done)
//
// Optional build macro:
//   BARCODE_PARITY_EN : appends a 10th cell carrying odd parity over the
//                       8 data bits, encoded like a data bit.
//
// States:
//   S_IDLE | BC high, waiting for send
//   S_LOW  | low portion of the current cell
//   S_HIGH | high portion of the current cell
//   S_DONE | single cycle, BC_done asserted
// ---------------------------------------------------------------------------
module barcode_tx #(
    parameter int MIN_PERIOD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    barcode_tx_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOW  = 2'd1,
        S_HIGH = 2'd2,
        S_DONE = 2'd3
    } state_t;

`ifdef BARCODE_PARITY_EN
    localparam logic [3:0] LAST_CELL = 4'd9;
`else
    localparam logic [3:0] LAST_CELL = 4'd8;
`endif

    state_t      r_state;
    logic [21:0] r_p;
    logic [21:0] r_cnt;
    logic [3:0]  r_cell;
    logic [7:0]  r_shift;
    logic        r_bc;
    logic        r_done;

    state_t      w_state_nxt;
    logic [21:0] w_p_nxt;
    logic [21:0] w_cnt_nxt;
    logic [3:0]  w_cell_nxt;
    logic [7:0]  w_shift_nxt;
    logic        w_bc_nxt;
    logic        w_done_nxt;
    logic [21:0] w_p_in;
    logic        w_bit;
    logic [21:0] w_low;

`ifdef BARCODE_PARITY_EN
    logic        r_par;
    logic        w_par_nxt;
`endif

    always_comb begin
        w_p_in = (bus.period < 22'(MIN_PERIOD)) ? 22'(MIN_PERIOD) : bus.period;
    end

    // Data bit for the current cell: the shift register MSB walks through
    // bits 7..0; the parity cell uses the bit latched at acceptance.
    always_comb begin
`ifdef BARCODE_PARITY_EN
        w_bit = (r_cell == LAST_CELL) ? r_par : r_shift[7];
`else
        w_bit = r_shift[7];
`endif
        if (r_cell == 4'd0) begin
            w_low = r_p >> 1;
        end else if (w_bit) begin
            w_low = r_p >> 2;
        end else begin
            w_low = r_p - (r_p >> 2);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_p_nxt     = r_p;
        w_cnt_nxt   = r_cnt;
        w_cell_nxt  = r_cell;
        w_shift_nxt = r_shift;
`ifdef BARCODE_PARITY_EN
        w_par_nxt   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                if (bus.send) begin
                    w_state_nxt = S_LOW;
                    w_p_nxt     = w_p_in;
                    w_shift_nxt = bus.station_ID;
                    w_cnt_nxt   = 22'd0;
                    w_cell_nxt  = 4'd0;
`ifdef BARCODE_PARITY_EN
                    w_par_nxt   = ~^bus.station_ID;
`endif
                end
            end
            S_LOW: begin
                // r_cnt counts clocks since the cell's falling edge.
                w_cnt_nxt = r_cnt + 22'd1;
                if (r_cnt == w_low - 22'd1) begin
                    w_state_nxt = S_HIGH;
                end
            end
            S_HIGH: begin
                if (r_cnt == r_p - 22'd1) begin
                    w_cnt_nxt = 22'd0;
                    if (r_cell != 4'd0) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                    end
                    if (r_cell == LAST_CELL) begin
                        w_state_nxt = S_DONE;
                    end else begin
                        w_cell_nxt  = r_cell + 4'd1;
                        w_state_nxt = S_LOW;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + 22'd1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 22'd0;
                w_cell_nxt  = 4'd0;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so BC falls on the
        // edge that accepts send and BC_done aligns with S_DONE.
        w_bc_nxt   = (w_state_nxt != S_LOW);
        w_done_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_p     <= 22'd0;
            r_cnt   <= 22'd0;
            r_cell  <= 4'd0;
            r_shift <= 8'd0;
            r_bc    <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_p     <= w_p_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cell  <= w_cell_nxt;
            r_shift <= w_shift_nxt;
            r_bc    <= w_bc_nxt;
            r_done  <= w_done_nxt;
        end
    end

`ifdef BARCODE_PARITY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_par <= 1'b0;
        end else begin
            r_par <= w_par_nxt;
        end
    end
`endif

    assign bus.BC      = r_bc;
    assign bus.BC_done = r_done;

endmodule

// File: tb/tb_barcode_tx.sv
// ---------------------------------------------------------------------------
// tb_barcode_tx
// Self-checking bench for barcode_tx. Expected waveforms come from a cell
// model (cell index, offset within cell, low-time rule); captured traces
// are also decoded independently by locating falling edges.
// ---------------------------------------------------------------------------
module tb_barcode_tx;

    logic clk = 1'b0;
    logic rst_n;
    always #10 clk = ~clk;

    barcode_tx_if bif();

    barcode_tx #(.MIN_PERIOD(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.slave)
    );

`ifdef BARCODE_PARITY_EN
    localparam int NCELLS = 10;
`else
    localparam int NCELLS = 9;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [21:0] period;
        logic [7:0]  id;
        int          exp_p;
        int          exp_start_low;
        bit          mid_send;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Low duration of cell c for clamped period p and ID id.
    function automatic int model_low(input int p, input logic [7:0] id, input int c);
        bit b;
        if (c == 0) return p / 2;
        if (c <= 8) b = id[8 - c];
        else        b = ~^id;
        return b ? (p / 4) : (p - p / 4);
    endfunction

    task automatic idle_check(input int n, input string tag);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (bif.BC !== 1'b1 || bif.BC_done !== 1'b0) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Issues a send and captures BC each cycle until BC_done (bounded).
    // Returns at the negedge on which BC_done is high, so a following call
    // sends in the cycle right after BC_done.
    task automatic run_frame(input logic [21:0] per, input logic [7:0] id,
                             input int exp_p, input int exp_start_low,
                             input bit mid_send, input string tag);
        bit tr[$];
        int falls[$];
        int t;
        int mism;
        int idx;
        int slow;
        bit seen;
        bit expv;
        logic [7:0] dec;

        @(negedge clk);
        check({tag, " idle_before"}, {bif.BC, bif.BC_done}, 2'b10);
        bif.period     = per;
        bif.station_ID = id;
        bif.send       = 1'b1;
        @(negedge clk);
        bif.send       = 1'b0;
        bif.period     = 22'($urandom);
        bif.station_ID = 8'($urandom);

        t = 0;
        seen = 1'b0;
        while (!seen && t < NCELLS * exp_p + 50) begin
            if (bif.BC_done === 1'b1) begin
                seen = 1'b1;
            end else begin
                tr.push_back(bif.BC);
                t++;
                bif.send = mid_send && (t == 3 * exp_p + 5);
                if (bif.send) bif.station_ID = ~id;
                @(negedge clk);
            end
        end
        bif.send = 1'b0;

        check({tag, " done_seen"}, seen, 1);
        check({tag, " frame_len"}, t, NCELLS * exp_p);
        check({tag, " bc_at_done"}, bif.BC, 1);

        mism = 0;
        for (int i = 0; i < tr.size(); i++) begin
            if (i / exp_p < NCELLS) expv = ((i % exp_p) >= model_low(exp_p, id, i / exp_p));
            else                    expv = 1'b1;
            if (tr[i] != expv) mism++;
        end
        check({tag, " wave_mismatches"}, mism, 0);

        for (int i = 0; i < tr.size(); i++) begin
            if (tr[i] == 1'b0 && (i == 0 || tr[i-1] == 1'b1)) falls.push_back(i);
        end
        check({tag, " fall_count"}, falls.size(), NCELLS);
        if (falls.size() >= NCELLS) begin
            check({tag, " cell_len"}, falls[1] - falls[0], exp_p);
            check({tag, " first_fall_t"}, falls[0], 0);
            slow = 0;
            while (falls[0] + slow < tr.size() && tr[falls[0] + slow] == 1'b0) slow++;
            check({tag, " start_low"}, slow, exp_start_low);
            dec = 8'h00;
            for (int k = 1; k <= 8; k++) begin
                idx = falls[k] + exp_start_low;
                dec = {dec[6:0], (idx < tr.size()) ? tr[idx] : 1'b0};
            end
            check({tag, " decoded_id"}, dec, id);
            if (NCELLS == 10) begin
                idx = falls[9] + exp_start_low;
                check({tag, " parity_bit"}, (idx < tr.size()) ? tr[idx] : 1'b0, ~^id);
            end
        end
    endtask

    initial begin
        vec_t vecs[6];
        logic [21:0] rp;
        logic [7:0]  rid;
        int          ep;

        vecs[0] = '{22'h1000, 8'h01, 4096, 2048, 1'b0};
        vecs[1] = '{22'h0100, 8'hA5, 256,  128,  1'b0};
        vecs[2] = '{22'd4,    8'h5A, 8,    4,    1'b0};
        vecs[3] = '{22'd0,    8'hFF, 8,    4,    1'b0};
        vecs[4] = '{22'd9,    8'h00, 9,    4,    1'b0};
        vecs[5] = '{22'd100,  8'h81, 100,  50,   1'b1};

        rst_n          = 1'b0;
        bif.send       = 1'b0;
        bif.period     = 22'd0;
        bif.station_ID = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_bc", bif.BC, 1);
        check("reset_done", bif.BC_done, 0);
        rst_n = 1'b1;
        idle_check(1000, "idle_1000");

        for (int v = 0; v < 6; v++) begin
            run_frame(vecs[v].period, vecs[v].id, vecs[v].exp_p,
                      vecs[v].exp_start_low, vecs[v].mid_send, $sformatf("vec%0d", v));
            idle_check(20, $sformatf("vec%0d post_idle", v));
        end

        // Back-to-back: second send lands in the cycle after BC_done.
        run_frame(22'd64, 8'hC3, 64, 32, 1'b0, "b2b_first");
        run_frame(22'd64, 8'h3C, 64, 32, 1'b0, "b2b_second");
        idle_check(10, "b2b post_idle");

        for (int r = 0; r < 8; r++) begin
            rp  = 22'($urandom_range(0, 200));
            rid = 8'($urandom);
            ep  = (rp < 22'd8) ? 8 : int'(rp);
            run_frame(rp, rid, ep, ep / 2, 1'b0, $sformatf("rand%0d", r));
            if ($urandom_range(0, 1) == 1) idle_check(5, $sformatf("rand%0d post_idle", r));
        end
        idle_check(3, "rand post_idle");

        // Reset mid-frame: BC returns high asynchronously, no BC_done follows.
        @(negedge clk);
        bif.period     = 22'd64;
        bif.station_ID = 8'h00;
        bif.send       = 1'b1;
        @(negedge clk);
        bif.send = 1'b0;
        repeat (10) @(negedge clk);
        check("pre_reset_low", bif.BC, 0);
        rst_n = 1'b0;
        #1;
        check("async_reset_bc", bif.BC, 1);
        check("async_reset_done", bif.BC_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(64 * 11, "no_done_after_reset");

        run_frame(22'd4, 8'h96, 8, 4, 1'b0, "after_reset");
        idle_check(5, "final_idle");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
